// File: rtl/addr_dec_pkg.sv
// Shared types and defaults for the address decoder: FSM states, region/I-O base tables
// and the lowest-index priority match used to pick exactly one chip select.
package addr_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } ctr_state_e;

   localparam logic [15:0] DEF_REG_BASE = {4'hF, 4'hE, 4'h1, 4'h0};
   localparam logic [11:0] DEF_REG_WS   = {3'd2, 3'd1, 3'd0, 3'd0};
   localparam logic [31:0] DEF_IO_BASE  = {8'h03, 8'h02, 8'h01, 8'h00};

   // Index of the lowest set bit, or -1 when nothing matched.
   function automatic int first_hit(input logic [31:0] hits);
      int idx;
      idx = -1;
      for (int i = 31; i >= 0; i--) begin
         if (hits[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/addr_dec_ws_ctr.sv
// Wait-state FSM: ready drops for exactly i_n cycles after a strobe starts (0 = no drop).
// Latency: ready falls the cycle after the strobe edge; an aborted or reset wait releases ready next cycle.
module addr_dec_ws_ctr
   import addr_dec_pkg::*;
#(
   parameter int WS_W = 3
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stb,
   input  logic [WS_W-1:0] i_n,
   output logic            o_ready
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_WAIT = ST_WAIT;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]      r_state;
   logic [WS_W-1:0] r_cnt;
   logic            r_stb_q;
   logic            w_stb_start;

   assign w_stb_start = i_stb & ~r_stb_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_stb_q <= 1'b0;
      end else begin
         r_stb_q <= i_stb;
         case (r_state)
            S_IDLE: begin
               if (w_stb_start) begin
                  if (i_n != '0) begin
                     r_cnt   <= i_n;
                     r_state <= S_WAIT;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_WAIT: begin
               // A strobe released mid-wait is an aborted cycle: drop straight back to idle.
               if (!i_stb) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if ((r_cnt == WS_W'(1)) || (r_cnt == '0)) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - WS_W'(1);
               end
            end
            S_DONE: begin
               if (!i_stb) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_ready = (r_state != S_WAIT);

endmodule

// File: rtl/addr_dec_ws.sv
// Bus address decoder: latches the address on ale, drives registered chip selects (1 cycle after ale),
// combinational byte write strobes and a wait-state READY. Optional I/O selects with ADDR_DEC_WS_IO_EN.
module addr_dec_ws
   import addr_dec_pkg::*;
#(
   parameter int                   NREG     = 4,
   parameter int                   AW       = 4,
   parameter int                   WS_W     = 3,
   parameter logic [NREG*AW-1:0]   REG_BASE = DEF_REG_BASE,
   parameter logic [NREG*WS_W-1:0] REG_WS   = DEF_REG_WS,
   parameter logic [WS_W-1:0]      IO_WS    = 3'd1
`ifdef ADDR_DEC_WS_IO_EN
   ,
   parameter int                   NIO      = 4,
   parameter logic [NIO*8-1:0]     IO_BASE  = DEF_IO_BASE
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ale,
   input  logic            m_ioN,
   input  logic [AW-1:0]   a_hi,
   input  logic            bheN,
   input  logic            a0,
   input  logic            rdN,
   input  logic            wrN,
   output logic [NREG-1:0] csN,
   output logic            wrhN,
   output logic            wrlN,
   output logic            ready
`ifdef ADDR_DEC_WS_IO_EN
   ,
   input  logic [7:0]      a_io,
   output logic [NIO-1:0]  io_csN
`endif
);

   logic            r_m_io;
   logic [AW-1:0]   r_a_hi;
   logic            r_bheN;
   logic            r_a0;
   logic [NREG-1:0] r_csN;

   logic [NREG-1:0] w_hit;
   int              w_idx;
   logic [NREG-1:0] w_csN_nxt;
   logic [WS_W-1:0] w_n;
   logic            w_stb;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_io <= 1'b0;
         r_a_hi <= '0;
         r_bheN <= 1'b1;
         r_a0   <= 1'b1;
         r_csN  <= '1;
      end else begin
         if (ale) begin
            r_m_io <= m_ioN;
            r_a_hi <= a_hi;
            r_bheN <= bheN;
            r_a0   <= a0;
         end
         r_csN <= w_csN_nxt;
      end
   end

   // Overlapping bases resolve to the lowest index so at most one select is ever low.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NREG; i++) begin
         w_hit[i] = r_m_io && (r_a_hi == REG_BASE[i*AW +: AW]);
      end
   end

   assign w_idx = first_hit(32'(w_hit));

   always_comb begin
      w_csN_nxt = '1;
      w_n       = r_m_io ? '0 : IO_WS;
      for (int i = 0; i < NREG; i++) begin
         if (w_idx == i) begin
            w_csN_nxt[i] = 1'b0;
            w_n          = REG_WS[i*WS_W +: WS_W];
         end
      end
   end

   assign csN   = r_csN;
   assign wrlN  = wrN | r_a0;
   assign wrhN  = wrN | r_bheN;
   assign w_stb = ~rdN | ~wrN;

   addr_dec_ws_ctr #(
      .WS_W (WS_W)
   ) u_ctr (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_stb   (w_stb),
      .i_n     (w_n),
      .o_ready (ready)
   );

`ifdef ADDR_DEC_WS_IO_EN
   logic [7:0]     r_a_io;
   logic [NIO-1:0] r_io_csN;
   logic [NIO-1:0] w_io_hit;
   int             w_io_idx;
   logic [NIO-1:0] w_io_csN_nxt;

   always_comb begin
      w_io_hit = '0;
      for (int i = 0; i < NIO; i++) begin
         w_io_hit[i] = !r_m_io && (r_a_io == IO_BASE[i*8 +: 8]);
      end
   end

   assign w_io_idx = first_hit(32'(w_io_hit));

   always_comb begin
      w_io_csN_nxt = '1;
      for (int i = 0; i < NIO; i++) begin
         if (w_io_idx == i) w_io_csN_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_io   <= '0;
         r_io_csN <= '1;
      end else begin
         if (ale) r_a_io <= a_io;
         r_io_csN <= w_io_csN_nxt;
      end
   end

   assign io_csN = r_io_csN;
`endif

endmodule

// File: tb/tb_addr_dec_ws.sv
// Self-checking bench for addr_dec_ws: directed scenarios plus randomized bus cycles against a table model.
module tb_addr_dec_ws;

   logic       clk = 1'b0;
   logic       rst, ale, m_ioN, bheN, a0, rdN, wrN;
   logic [3:0] a_hi;
   logic [3:0] csN;
   logic       wrhN, wrlN, ready;
`ifdef ADDR_DEC_WS_IO_EN
   logic [7:0] a_io;
   logic [3:0] io_csN;
`endif

   int errors = 0;
   int checks = 0;

   int reg_base[4] = '{4'h0, 4'h1, 4'hE, 4'hF};
   int reg_ws[4]   = '{0, 0, 1, 2};
   int io_ws       = 1;

   always #5 clk = ~clk;

   addr_dec_ws dut (
      .clk    (clk),
      .rst    (rst),
      .ale    (ale),
      .m_ioN  (m_ioN),
      .a_hi   (a_hi),
      .bheN   (bheN),
      .a0     (a0),
      .rdN    (rdN),
      .wrN    (wrN),
      .csN    (csN),
      .wrhN   (wrhN),
      .wrlN   (wrlN),
      .ready  (ready)
`ifdef ADDR_DEC_WS_IO_EN
      ,
      .a_io   (a_io),
      .io_csN (io_csN)
`endif
   );

   function automatic logic [3:0] model_cs(input logic mem, input logic [3:0] a);
      logic [3:0] r;
      r = 4'b1111;
      if (mem) begin
         for (int i = 0; i < 4; i++) begin
            if (a == reg_base[i]) begin
               r[i] = 1'b0;
               break;
            end
         end
      end
      return r;
   endfunction

   function automatic int model_ws(input logic mem, input logic [3:0] a);
      if (!mem) return io_ws;
      for (int i = 0; i < 4; i++) begin
         if (a == reg_base[i]) return reg_ws[i];
      end
      return 0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic latch(input logic m, input logic [3:0] a, input logic bh, input logic b0);
      ale   = 1'b1;
      m_ioN = m;
      a_hi  = a;
      bheN  = bh;
      a0    = b0;
      tick();
      ale = 1'b0;
   endtask

   // Counts cycles with ready low after the strobe edge; -1 if ready never returns.
   task automatic count_wait(output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (ready) return;
         n++;
      end
      n = -1;
   endtask

   task automatic release_bus;
      rdN = 1'b1;
      wrN = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (csN !== 4'b1111) begin errors++; $display("FAIL reset_csN: got %b want %b", csN, 4'b1111); end
      checks++; if (wrhN !== 1'b1) begin errors++; $display("FAIL reset_wrhN: got %b want 1", wrhN); end
      checks++; if (wrlN !== 1'b1) begin errors++; $display("FAIL reset_wrlN: got %b want 1", wrlN); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
      rst = 1'b0;
      tick();
      checks++; if (ready !== 1'b1 || csN !== 4'b1111) begin errors++; $display("FAIL idle_after_reset: ready=%b csN=%b want 1/1111", ready, csN); end
   endtask

   task automatic test_mem_read_ws2;
      int n;
      latch(1'b1, 4'hF, 1'b1, 1'b1);
      checks++; if (csN !== 4'b1111) begin errors++; $display("FAIL cs_not_yet: got %b want %b", csN, 4'b1111); end
      rdN = 1'b0;
      count_wait(n);
      checks++; if (n !== 2) begin errors++; $display("FAIL read_ws2_count: got %0d want 2", n); end
      checks++; if (csN !== 4'b0111) begin errors++; $display("FAIL read_ws2_csN: got %b want %b", csN, 4'b0111); end
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL read_ws2_held: got %b want 1", ready); end
      release_bus();
   endtask

   task automatic test_mem_write_ws0;
      int n;
      latch(1'b1, 4'h0, 1'b1, 1'b0);
      wrN = 1'b0;
      #1;
      checks++; if (wrlN !== 1'b0) begin errors++; $display("FAIL wr0_wrlN: got %b want 0", wrlN); end
      checks++; if (wrhN !== 1'b1) begin errors++; $display("FAIL wr0_wrhN: got %b want 1", wrhN); end
      count_wait(n);
      checks++; if (n !== 0) begin errors++; $display("FAIL wr0_count: got %0d want 0", n); end
      checks++; if (csN !== 4'b1110) begin errors++; $display("FAIL wr0_csN: got %b want %b", csN, 4'b1110); end
      release_bus();
      checks++; if (wrlN !== 1'b1) begin errors++; $display("FAIL wr0_wrlN_release: got %b want 1", wrlN); end
   endtask

   task automatic test_io_write;
      int n;
      latch(1'b0, 4'h0, 1'b0, 1'b1);
      wrN = 1'b0;
      #1;
      checks++; if (wrhN !== 1'b0) begin errors++; $display("FAIL io_wrhN: got %b want 0", wrhN); end
      checks++; if (wrlN !== 1'b1) begin errors++; $display("FAIL io_wrlN: got %b want 1", wrlN); end
      count_wait(n);
      checks++; if (n !== 1) begin errors++; $display("FAIL io_count: got %0d want 1", n); end
      checks++; if (csN !== 4'b1111) begin errors++; $display("FAIL io_csN: got %b want %b", csN, 4'b1111); end
      release_bus();
   endtask

   task automatic test_abort;
      int n;
      latch(1'b1, 4'hF, 1'b1, 1'b1);
      rdN = 1'b0;
      tick();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_wait: got %b want 0", ready); end
      rdN = 1'b1;
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
      tick();
      rdN = 1'b0;
      count_wait(n);
      checks++; if (n !== 2) begin errors++; $display("FAIL abort_restart_count: got %0d want 2", n); end
      release_bus();
   endtask

   task automatic test_reset_mid_wait;
      latch(1'b1, 4'hF, 1'b1, 1'b1);
      rdN = 1'b0;
      tick();
      checks++; if (ready !== 1'b0 || csN !== 4'b0111) begin errors++; $display("FAIL rstwait_pre: ready=%b csN=%b want 0/0111", ready, csN); end
      rst = 1'b1;
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready: got %b want 1", ready); end
      checks++; if (csN !== 4'b1111) begin errors++; $display("FAIL rstwait_csN: got %b want %b", csN, 4'b1111); end
      rst = 1'b0;
      release_bus();
   endtask

   task automatic test_ale_in_wait;
      int n;
      latch(1'b1, 4'hF, 1'b1, 1'b1);
      rdN = 1'b0;
      tick();
      ale  = 1'b1;
      a_hi = 4'h0;
      tick();
      ale = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL alewait_still_low: got %b want 0", ready); end
      count_wait(n);
      checks++; if (n !== 0) begin errors++; $display("FAIL alewait_remaining: got %0d want 0", n); end
      checks++; if (csN !== 4'b1110) begin errors++; $display("FAIL alewait_csN: got %b want %b", csN, 4'b1110); end
      release_bus();
   endtask

`ifdef ADDR_DEC_WS_IO_EN
   task automatic test_io_select;
      a_io = 8'h02;
      latch(1'b0, 4'h0, 1'b1, 1'b1);
      tick();
      checks++; if (io_csN !== 4'b1011) begin errors++; $display("FAIL iosel_io_csN: got %b want %b", io_csN, 4'b1011); end
      checks++; if (csN !== 4'b1111) begin errors++; $display("FAIL iosel_csN: got %b want %b", csN, 4'b1111); end
      latch(1'b1, 4'h0, 1'b1, 1'b1);
      tick();
      checks++; if (io_csN !== 4'b1111) begin errors++; $display("FAIL iosel_mem_io_csN: got %b want %b", io_csN, 4'b1111); end
   endtask
`endif

   task automatic test_random;
      int n, sel, kind, exp_n;
      logic m, bh, b0, rd, wr;
      logic [3:0] a;
      for (int it = 0; it < 40; it++) begin
         m    = 1'($urandom_range(0, 1));
         bh   = 1'($urandom_range(0, 1));
         b0   = 1'($urandom_range(0, 1));
         sel  = int'($urandom_range(0, 4));
         a    = (sel < 4) ? 4'(reg_base[sel]) : 4'($urandom_range(0, 15));
         kind = int'($urandom_range(1, 3));
         rd   = ((kind & 1) != 0) ? 1'b0 : 1'b1;
         wr   = ((kind & 2) != 0) ? 1'b0 : 1'b1;
         exp_n = model_ws(m, a);
         latch(m, a, bh, b0);
         rdN = rd;
         wrN = wr;
         #1;
         checks++; if (wrlN !== (wr | b0)) begin errors++; $display("FAIL rnd_wrlN it=%0d: got %b want %b", it, wrlN, wr | b0); end
         checks++; if (wrhN !== (wr | bh)) begin errors++; $display("FAIL rnd_wrhN it=%0d: got %b want %b", it, wrhN, wr | bh); end
         count_wait(n);
         checks++; if (n !== exp_n) begin errors++; $display("FAIL rnd_count it=%0d: got %0d want %0d", it, n, exp_n); end
         checks++; if (csN !== model_cs(m, a)) begin errors++; $display("FAIL rnd_csN it=%0d: got %b want %b", it, csN, model_cs(m, a)); end
         release_bus();
      end
   endtask

   initial begin
      rst   = 1'b1;
      ale   = 1'b0;
      m_ioN = 1'b1;
      a_hi  = 4'h0;
      bheN  = 1'b1;
      a0    = 1'b1;
      rdN   = 1'b1;
      wrN   = 1'b1;
`ifdef ADDR_DEC_WS_IO_EN
      a_io  = 8'h00;
`endif
      test_reset();
      test_mem_read_ws2();
      test_mem_write_ws0();
      test_io_write();
      test_abort();
      test_reset_mid_wait();
      test_ale_in_wait();
`ifdef ADDR_DEC_WS_IO_EN
      test_io_select();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/addr_dec_ws.md
Name: addr_dec_ws

Overview:
- Parametrised successor to the 8086-style memory/EPROM address decoder.
- Latches the bus address on ALE and decodes NREG memory regions into active-low chip selects.
- Generates the byte-lane write strobes and a READY output with a per-region wait-state count.
- Sits between the CPU bus demultiplexer and the RAM/EPROM/peripheral selects in the system top.

Parameters:
- NREG, 4: number of memory regions / csN outputs.
- AW, 4: width of the high address field compared (a_hi = A19..A16 by default).
- WS_W, 3: width of one wait-state count.
- REG_BASE, {4'hF,4'hE,4'h1,4'h0}: packed NREG*AW base values. Region i matches when a_hi == REG_BASE[i].
- REG_WS, {3'd2,3'd1,3'd0,3'd0}: packed NREG*WS_W wait states for region i.
- IO_WS, 3'd1: wait states for any I/O cycle (m_ioN=0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ale  in  1  address latch enable, sampled on clk
- m_ioN  in  1  1 = memory cycle, 0 = I/O cycle
- a_hi  in  AW  high address bits
- bheN  in  1  bus high enable, active low
- a0  in  1  address bit 0
- rdN  in  1  read strobe, active low
- wrN  in  1  write strobe, active low
- csN  out  NREG  region chip selects, active low
- wrhN  out  1  high-byte write strobe, active low
- wrlN  out  1  low-byte write strobe, active low
- ready  out  1  CPU READY, high = no wait

Behaviour:
- Reset (clk edge with rst=1):
  - Latched m_io=0, a_hi=0, bheN=1, a0=1.
  - csN all 1s, wrhN=wrlN=1, ready=1.
  - FSM in IDLE, counter=0.
  - Reset mid-WAIT aborts the wait; ready=1 on the next cycle.
- Address latch: on a clk edge with ale=1, register m_ioN, a_hi, bheN and a0. ale during WAIT relatches the address but does not disturb the FSM or counter.
- Decode: csN is registered from the latched fields, so it updates 1 cycle after ale is sampled.
  - csN[i]=0 iff latched m_io=1 and latched a_hi==REG_BASE[i].
  - On overlapping bases, only the lowest matching index asserts. At most one csN is low.
  - No match: all csN are 1.
- Write strobes (combinational from wrN and the latched fields):
  - wrlN = wrN | a0_latched.
  - wrhN = wrN | bheN_latched.
- Strobe: stb = ~rdN | ~wrN. stb_start = stb & ~stb_q, where stb_q is stb registered one cycle. rdN and wrN both low counts as one strobe.
- Wait count N:
  - Memory cycle: REG_WS of the matching region.
  - Memory cycle with no match: N=0.
  - I/O cycle: N=IO_WS.
- FSM:
  - IDLE: ready=1. On stb_start, if N>0 load counter=N and go to WAIT; else go to DONE.
  - WAIT: ready=0. Counter decrements each clk; at counter==1 go to DONE. ready is low for exactly N cycles, starting the cycle after stb_start is sampled.
  - DONE: ready=1. Return to IDLE when stb=0.
  - stb=0 while in WAIT (aborted cycle): go to IDLE, ready=1 next cycle.
- ready is registered (driven from the state register); counter arithmetic is unsigned WS_W bits and never wraps below 0.

Optional Feature:
- Macro: ADDR_DEC_WS_IO_EN.
- Defined:
  - Adds parameters NIO (default 4) and IO_BASE (packed NIO*8, default {8'h03,8'h02,8'h01,8'h00}).
  - Adds input a_io[7:0] (A15..A8), latched on ale.
  - Adds output io_csN[NIO], active low.
  - io_csN[i]=0 iff latched m_io=0 and a_io==IO_BASE[i], with lowest-index priority and 1-cycle latency as for csN.
  - Reset value of io_csN is all 1s.
- Undefined: these parameters and ports are absent; I/O cycles still insert IO_WS wait states.

Decomposition:
- Package addr_dec_pkg holds:
  - FSM state enum (IDLE, WAIT, DONE).
  - Default REG_BASE, REG_WS and IO_BASE constants.
  - Function for lowest-index priority match.
- One sub-module, addr_dec_ws_ctr, contains the FSM and down-counter. Inputs: clk, rst, stb, N. Output: ready.
- The top level holds the latch, decode and write strobes.

Test Plan:
- Reset then idle: csN=4'b1111, wrhN=wrlN=1, ready=1 after rst deasserts.
- ale with m_ioN=1, a_hi=4'hF; then rdN=0 -> csN=4'b0111 one cycle after ale, ready low exactly 2 cycles, ready returns to 1 while rdN is held 0.
- ale with a_hi=4'h0, a0=0, bheN=1; then wrN=0 -> csN=4'b1110, wrlN=0, wrhN=1, ready never drops (WS=0).
- I/O cycle (m_ioN=0, a_hi=4'h0) with wrN=0, bheN=0, a0=1 -> csN=4'b1111, wrhN=0, wrlN=1, ready low 1 cycle.
- Abort and reset:
  - a_hi=4'hF, rdN released after 1 wait cycle -> ready=1 next cycle, FSM back to IDLE.
  - Repeat the cycle with rst asserted during WAIT -> ready=1 and csN=4'b1111 next cycle.
- With ADDR_DEC_WS_IO_EN: m_ioN=0, a_io=8'h02 -> io_csN=4'b1011, csN=4'b1111.
